// File: rtl/mem_responder_pkg.sv
// Shared definitions for the RAM-port responder.
// Address field layout, default error data and response encoding.
package mem_responder_pkg;

   // Byte-offset width inside a 32-bit word.
   localparam int WORD_LSB = 2;

   localparam logic [31:0] ERR_DATA_DFLT = 32'h0000_0000;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   // Completion type as seen by the control unit.
   typedef enum logic [1:0] {
      RESP_NONE  = 2'd0,
      RESP_READ  = 2'd1,
      RESP_WRITE = 2'd2
   } resp_e;

endpackage

// File: rtl/mem_responder_read_pipe.sv
// Fixed-latency read return pipe: LAT-deep shift of {valid, err, data}.
// Ports: clk, reset (async low), valid_i/err_i/data_i in, valid_o/err_o/data_o/busy_o out.
module mem_responder_read_pipe #(
   parameter int LAT = 1,
   parameter int DW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_i,
   input  logic          err_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic          err_o,
   output logic [DW-1:0] data_o,
   output logic          busy_o
);

   logic [LAT-1:0] r_v;
   logic [LAT-1:0] r_e;
   logic [DW-1:0]  r_d [LAT];

   // Data registers only move with a valid entry, so the last stage
   // keeps the most recent response between completions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v <= '0;
         r_e <= '0;
         for (int i = 0; i < LAT; i++) r_d[i] <= '0;
      end else begin
         r_v[0] <= valid_i;
         r_e[0] <= err_i;
         if (valid_i) r_d[0] <= data_i;
         for (int i = 1; i < LAT; i++) begin
            r_v[i] <= r_v[i-1];
            r_e[i] <= r_e[i-1];
            if (r_v[i-1]) r_d[i] <= r_d[i-1];
         end
      end
   end

   assign valid_o = r_v[LAT-1];
   assign err_o   = r_v[LAT-1] & r_e[LAT-1];
   assign data_o  = r_d[LAT-1];
   assign busy_o  = |r_v;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM, error decode, read pipe, error counter.
// Ports: clk, reset (async low), req_i/we_i/addr_i/data_i in; data_o/rvalid_o/wack_o/err_o/busy_o/err_count_o out.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] ERR_DATA     = ERR_DATA_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        rvalid_o,
   output logic        wack_o,
   output logic        err_o,
   output logic        busy_o,
   output logic [7:0]  err_count_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int HW = 32 - WORD_LSB;

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic          r_wack;
   logic          r_werr;
   logic [7:0]    r_err_cnt;

   logic          w_misal;
   logic          w_oor;
   logic          w_err;
   logic          w_wr_ok;
   logic          w_rd;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_rd_data;
   logic          w_pv;
   logic          w_pe;

   assign w_misal   = |addr_i[WORD_LSB-1:0];
   assign w_oor     = addr_i[31:WORD_LSB] >= HW'(DEPTH_WORDS);
   assign w_err     = w_misal | w_oor;
   assign w_idx     = addr_i[WORD_LSB +: AW];
   assign w_wr_ok   = reset & req_i & we_i & ~w_err;
   assign w_rd      = req_i & ~we_i;
   assign w_rd_data = w_err ? ERR_DATA : r_mem[w_idx];

   // Array is not reset; writes are blocked while reset is low.
   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[w_idx] <= data_i;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wack    <= 1'b0;
         r_werr    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_wack <= req_i & we_i;
         r_werr <= req_i & we_i & w_err;
         if (req_i && w_err && r_err_cnt != ERR_CNT_MAX)
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   mem_responder_read_pipe #(
      .LAT (READ_LATENCY),
      .DW  (32)
   ) u_read_pipe (
      .clk     (clk),
      .reset   (reset),
      .valid_i (w_rd),
      .err_i   (w_err),
      .data_i  (w_rd_data),
      .valid_o (w_pv),
      .err_o   (w_pe),
      .data_o  (data_o),
      .busy_o  (busy_o)
   );

   assign rvalid_o    = w_pv;
   assign wack_o      = r_wack;
   assign err_o       = w_pe | (r_wack & r_werr);
   assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four latencies side by side vs a scoreboard.
// Expected responses are scheduled by due cycle from plain memory rules.
module tb_mem_responder;

   localparam int          DEPTH = 64;
   localparam logic [31:0] EDATA = 32'hDEAD_BEEF;
   localparam int          ND    = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;

   logic [31:0] data_o [ND];
   logic        rvalid_o [ND];
   logic        wack_o [ND];
   logic        err_o [ND];
   logic        busy_o [ND];
   logic [7:0]  cnt_o [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      mem_responder #(
         .DEPTH_WORDS  (DEPTH),
         .READ_LATENCY (g + 1),
         .ERR_DATA     (EDATA)
      ) u_dut (
         .clk         (clk),
         .reset       (rst_n),
         .req_i       (req_i),
         .we_i        (we_i),
         .addr_i      (addr_i),
         .data_i      (data_i),
         .data_o      (data_o[g]),
         .rvalid_o    (rvalid_o[g]),
         .wack_o      (wack_o[g]),
         .err_o       (err_o[g]),
         .busy_o      (busy_o[g]),
         .err_count_o (cnt_o[g])
      );
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] mmem [DEPTH];
   bit   [7:0]  pv [ND];
   logic [31:0] pd [ND][8];
   bit          pe [ND][8];
   logic [31:0] last [ND];
   bit          ew;
   bit          ewe;
   int          cnt;

   task automatic chk(input string tag, input int k,
                      input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h",
                tag, k, cyc, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < ND; k++) begin
         pv[k]   = '0;
         last[k] = '0;
      end
      ew  = 0;
      ewe = 0;
      cnt = 0;
   endtask

   task automatic check_all();
      int  s;
      bit  ev;
      bit  eb;
      bit  ee;
      s = cyc % 8;
      for (int k = 0; k < ND; k++) begin
         ev = pv[k][s];
         eb = |pv[k];
         if (ev) last[k] = pd[k][s];
         ee = (ev && pe[k][s]) || (ew && ewe);
         chk("rvalid", k, 32'(rvalid_o[k]), 32'(ev));
         chk("data", k, data_o[k], last[k]);
         chk("wack", k, 32'(wack_o[k]), 32'(ew));
         chk("err", k, 32'(err_o[k]), 32'(ee));
         chk("busy", k, 32'(busy_o[k]), 32'(eb));
         chk("errcnt", k, 32'(cnt_o[k]), 32'(cnt));
         pv[k][s] = 1'b0;
      end
   endtask

   task automatic tick(input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
      bit e;
      int s;
      req_i  = r;
      we_i   = w;
      addr_i = a;
      data_i = d;
      @(posedge clk);
      #1;
      cyc++;
      ew  = 0;
      ewe = 0;
      if (rst_n && r) begin
         e = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
         if (e && cnt < 255) cnt++;
         if (w) begin
            ew  = 1;
            ewe = e;
            if (!e) mmem[a >> 2] = d;
         end else begin
            for (int k = 0; k < ND; k++) begin
               s = (cyc + k) % 8;
               pv[k][s] = 1'b1;
               pd[k][s] = e ? EDATA : mmem[a >> 2];
               pe[k][s] = e;
            end
         end
      end
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      bit          r;
      bit          w;
      logic [31:0] a;
      rst_n  = 1'b0;
      req_i  = 1'b0;
      we_i   = 1'b0;
      addr_i = '0;
      data_i = '0;
      model_clear();
      #1;
      check_all();
      tick(1, 1, 32'h0, 32'h1111_0000);
      tick(0, 0, 32'h0, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) tick(1, 1, 32'(i * 4), $urandom);
      tick(1, 1, 32'h0, 32'd1);
      tick(1, 1, 32'h4, 32'd2);
      tick(1, 1, 32'h8, 32'd3);

      tick(1, 1, 32'h10, 32'hCAFE_0001);
      tick(1, 0, 32'h10, 32'h0);
      idle(5);

      tick(1, 0, 32'h0, 32'h0);
      tick(1, 0, 32'h4, 32'h0);
      tick(1, 0, 32'h8, 32'h0);
      idle(6);

      tick(1, 0, 32'h13, 32'h0);
      tick(1, 0, 32'(4 * DEPTH), 32'h0);
      idle(5);
      tick(1, 0, 32'h0, 32'h0);
      tick(1, 0, 32'h10, 32'h0);
      idle(5);

      tick(1, 1, 32'h20, 32'h1234);
      tick(1, 0, 32'h20, 32'h0);
      idle(5);

      tick(1, 0, 32'h13, 32'h0);
      tick(1, 1, 32'h28, 32'h5555_AAAA);
      tick(1, 0, 32'h28, 32'h0);
      tick(1, 1, 32'h2D, 32'h0);
      idle(5);

      tick(1, 0, 32'h0, 32'h0);
      tick(1, 0, 32'h4, 32'h0);
      tick(1, 0, 32'h8, 32'h0);
      rst_n = 1'b0;
      model_clear();
      #1;
      check_all();
      tick(1, 1, 32'h0, 32'hBAD0_BAD0);
      rst_n = 1'b1;
      idle(6);
      tick(1, 0, 32'h0, 32'h0);
      idle(5);

      for (int i = 0; i < 300; i++) begin
         r = ($urandom % 4) != 0;
         w = ($urandom % 2) != 0;
         if (($urandom % 8) == 0) a = $urandom % (8 * DEPTH);
         else a = 32'($urandom_range(0, DEPTH - 1) * 4);
         tick(r, w, a, $urandom);
      end
      idle(5);

      for (int i = 0; i < 260; i++)
         tick(1, 1, (i % 2 == 0) ? 32'h13 : 32'h1000, $urandom);
      tick(1, 0, 32'h3, 32'h0);
      tick(1, 0, 32'h10, 32'h0);
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's RAM port. It is the target that the control unit's fetch and load/store accesses address.
- Holds a word-addressed RAM array.
- Accepts one request per cycle (read or write) over a request strobe.
- Returns read data through a fixed-latency pipeline.
- Flags misaligned and out-of-range accesses.
- Sits between the control unit (initiator) and the memory array, which is instantiated internally.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, minimum 16.
READ_LATENCY, 1, cycles from an accepted read to rvalid_o; legal range 1..4.
ERR_DATA, 32'h0000_0000, value returned on data_o for an erroneous read.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
req_i  input  1  request strobe; one access is accepted per cycle in which it is high.
we_i  input  1  1 = write, 0 = read; sampled with req_i.
addr_i  input  32  byte address; bits [1:0] must be 0.
data_i  input  32  write data from the initiator.
data_o  output  32  read data; valid when rvalid_o is 1, otherwise holds its last value.
rvalid_o  output  1  one-cycle pulse per completed read.
wack_o  output  1  one-cycle pulse, one cycle after an accepted write.
err_o  output  1  pulses together with rvalid_o or wack_o when the access was erroneous.
busy_o  output  1  high while any read is still in flight in the pipeline.
err_count_o  output  8  saturating count of erroneous accesses.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_o=0, rvalid_o=0, wack_o=0, err_o=0, busy_o=0, err_count_o=0.
  - All pipeline valid bits are cleared.
  - Array contents are not reset.
- Error classification, evaluated at acceptance:
  - Misaligned: addr_i[1:0] != 0.
  - Out-of-range: addr_i[31:2] >= DEPTH_WORDS.
  - Either condition makes the access erroneous.
- Write (req_i=1, we_i=1, not erroneous):
  - mem[addr_i[31:2]] <= data_i at that clock edge.
  - wack_o=1 in the following cycle.
- Erroneous write:
  - Array is unchanged.
  - wack_o=1 and err_o=1 in the following cycle.
  - err_count_o increments.
- Read (req_i=1, we_i=0):
  - Stage 1 captures mem[addr_i[31:2]] at the acceptance edge, or ERR_DATA if erroneous, along with the error bit.
  - Stages 2..READ_LATENCY shift the captured data forward.
  - rvalid_o=1 and data_o update exactly READ_LATENCY cycles after acceptance.
- Fully pipelined:
  - Back-to-back reads produce back-to-back rvalid_o pulses, in order.
  - There is no backpressure; the initiator must consume every response.
- Write then read of the same word on consecutive cycles: the read returns the newly written data.
- Only one access per cycle is possible, so simultaneous read and write cannot occur.
- Read and write completions in the same cycle are allowed:
  - Example: a read accepted at N with READ_LATENCY=2, and a write accepted at N+1.
  - Both rvalid_o and wack_o pulse; err_o is the OR of their two error bits.
- busy_o = OR of the read pipeline valid bits; writes do not set busy_o.
- err_count_o saturates at 255 and is cleared only by reset.
- req_i=0: no state change apart from the pipeline advancing.
- Reset mid-operation:
  - In-flight reads are dropped and no rvalid_o is produced for them.
  - A write coinciding with reset low is not performed.
  - After reset deasserts, the first accepted request behaves normally.
- data_o holds its last value between responses and on error-free idle cycles.

Decomposition:
- Shared package holds:
  - Address field constants: WORD_LSB=2, the byte-offset width.
  - The default ERR_DATA value.
  - The response-type encoding, if shared with the control unit.
- One natural sub-module, read_pipe:
  - A parameterised READ_LATENCY-deep shift register of {valid, err, data}.
  - Takes clk and active-low reset.
- Array, decode and counter stay in mem_responder.

Test Plan:
- Reset, then write 32'hCAFE_0001 to addr 0x10 and read 0x10 with READ_LATENCY=1 -> wack_o at +1; rvalid_o at +1 after the read, data_o=32'hCAFE_0001, err_o=0.
- READ_LATENCY=3, reads to 0x0, 0x4, 0x8 on consecutive cycles (preloaded 1, 2, 3) -> rvalid_o high 3 cycles in a row starting 3 cycles after the first request, data 1, 2, 3 in order; busy_o high throughout.
- Read addr 0x13 (misaligned), then read 4*DEPTH_WORDS (out-of-range) -> both return ERR_DATA with err_o=1; err_count_o=2; array unchanged.
- Write 0x1234 to 0x20, then read 0x20 on the next cycle -> data_o=0x1234.
- Issue 3 reads with READ_LATENCY=4 and pulse reset low on the cycle after the third -> no rvalid_o thereafter; data_o=0, busy_o=0, err_count_o=0.
- 260 erroneous writes -> err_count_o saturates at 255; every access still gets wack_o with err_o=1.
